// File: rtl/snoop_responder.sv
// Snoop responder: accepts one snooped bus operation at a time, looks up the
// line's MESI state, reports MISS/HIT/HITM, writes back dirty lines and then
// updates the line state (S for READ, I for everything else).
module snoop_responder (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        snoop_valid_i,
    input  logic [1:0]  snoop_op_i,
    input  logic [31:0] snoop_addr_i,
    output logic        snoop_ready_o,
    output logic        lookup_req_o,
    output logic [31:0] lookup_addr_o,
    input  logic        lookup_ack_i,
    input  logic [3:0]  lookup_state_i,
    output logic        hm_valid_o,
    output logic [1:0]  hm_out_o,
    output logic        wb_req_o,
    output logic [31:0] wb_addr_o,
    input  logic        wb_done_i,
    output logic        state_we_o,
    output logic [3:0]  state_new_o,
    output logic        proto_err_o,
    output logic [15:0] hitm_count_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        RESPOND   = 3'd2,
        WRITEBACK = 3'd3,
        UPDATE    = 3'd4
    } state_t;

    localparam logic [1:0] OP_READ = 2'd0;

    localparam logic [3:0] MESI_M = 4'b0001;
    localparam logic [3:0] MESI_E = 4'b0010;
    localparam logic [3:0] MESI_S = 4'b0100;
    localparam logic [3:0] MESI_I = 4'b1000;

    localparam logic [1:0] HM_MISS = 2'd0;
    localparam logic [1:0] HM_HIT  = 2'd1;
    localparam logic [1:0] HM_HITM = 2'd2;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  mesi_q, mesi_d;     // captured state, already normalised to one-hot
    logic        perr_q, perr_d;     // captured state was not one-hot
    logic [15:0] cnt_q, cnt_d;

    assign hitm_count_o = cnt_q;
    assign state_o      = state_q;

    // Next-state logic and Moore outputs; every output idles at 0.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        mesi_d        = mesi_q;
        perr_d        = perr_q;
        cnt_d         = cnt_q;
        snoop_ready_o = 1'b0;
        lookup_req_o  = 1'b0;
        lookup_addr_o = 32'd0;
        hm_valid_o    = 1'b0;
        hm_out_o      = HM_MISS;
        wb_req_o      = 1'b0;
        wb_addr_o     = 32'd0;
        state_we_o    = 1'b0;
        state_new_o   = 4'd0;
        proto_err_o   = 1'b0;

        case (state_q)
            IDLE: begin
                snoop_ready_o = 1'b1;
                if (snoop_valid_i) begin
                    op_d    = snoop_op_i;
                    addr_d  = snoop_addr_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                lookup_req_o  = 1'b1;
                lookup_addr_o = addr_q;
                if (lookup_ack_i) begin
                    case (lookup_state_i)
                        MESI_M, MESI_E, MESI_S, MESI_I: begin
                            mesi_d = lookup_state_i;
                            perr_d = 1'b0;
                        end
                        default: begin
                            // Corrupt state: behave as if the line is absent.
                            mesi_d = MESI_I;
                            perr_d = 1'b1;
                        end
                    endcase
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                hm_valid_o  = 1'b1;
                proto_err_o = perr_q;
                if (mesi_q == MESI_M) begin
                    hm_out_o = HM_HITM;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    state_d = WRITEBACK;
                end else begin
                    hm_out_o = (mesi_q == MESI_I) ? HM_MISS : HM_HIT;
                    state_d  = UPDATE;
                end
            end
            WRITEBACK: begin
                wb_req_o  = 1'b1;
                wb_addr_o = addr_q;
                if (wb_done_i) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                // A line that was already invalid needs no state write.
                if (mesi_q != MESI_I) begin
                    state_we_o  = 1'b1;
                    state_new_o = (op_q == OP_READ) ? MESI_S : MESI_I;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight snoop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= 2'd0;
            addr_q  <= 32'd0;
            mesi_q  <= MESI_I;
            perr_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            mesi_q  <= mesi_d;
            perr_q  <= perr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder: expected responses and line updates are
// queued when a snoop is driven and popped when the DUT produces them.
module tb_snoop_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        snoop_valid_i = 1'b0;
  logic [1:0]  snoop_op_i = 2'd0;
  logic [31:0] snoop_addr_i = 32'd0;
  logic        snoop_ready_o;
  logic        lookup_req_o;
  logic [31:0] lookup_addr_o;
  logic        lookup_ack_i = 1'b0;
  logic [3:0]  lookup_state_i = 4'd0;
  logic        hm_valid_o;
  logic [1:0]  hm_out_o;
  logic        wb_req_o;
  logic [31:0] wb_addr_o;
  logic        wb_done_i = 1'b0;
  logic        state_we_o;
  logic [3:0]  state_new_o;
  logic        proto_err_o;
  logic [15:0] hitm_count_o;
  logic [2:0]  state_o;

  int errors = 0;
  int checks = 0;
  logic [2:0]  exp_q[$];   // {proto_err, hm_out}
  logic [4:0]  upd_q[$];   // {state_we, state_new}
  logic [15:0] exp_hitm = 16'd0;

  snoop_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .snoop_valid_i(snoop_valid_i), .snoop_op_i(snoop_op_i), .snoop_addr_i(snoop_addr_i),
    .snoop_ready_o(snoop_ready_o),
    .lookup_req_o(lookup_req_o), .lookup_addr_o(lookup_addr_o),
    .lookup_ack_i(lookup_ack_i), .lookup_state_i(lookup_state_i),
    .hm_valid_o(hm_valid_o), .hm_out_o(hm_out_o),
    .wb_req_o(wb_req_o), .wb_addr_o(wb_addr_o), .wb_done_i(wb_done_i),
    .state_we_o(state_we_o), .state_new_o(state_new_o),
    .proto_err_o(proto_err_o), .hitm_count_o(hitm_count_o), .state_o(state_o)
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete snoop with immediate lookup ack and wb_wait extra WB cycles.
  task automatic run_snoop(input logic [1:0] op, input logic [31:0] addr,
                           input logic [3:0] lst, input int wb_wait);
    logic [3:0] m;
    logic       perr, we;
    logic [1:0] hm;
    logic [3:0] nw;
    logic [2:0] e_hm;
    logic [4:0] e_upd;
    int n;
    // reference model
    perr = !(lst inside {4'b0001, 4'b0010, 4'b0100, 4'b1000});
    m    = perr ? 4'b1000 : lst;
    hm   = (m == 4'b0001) ? 2'd2 : (m == 4'b1000) ? 2'd0 : 2'd1;
    we   = (m != 4'b1000);
    nw   = !we ? 4'd0 : (op == 2'd0) ? 4'b0100 : 4'b1000;
    exp_q.push_back({perr, hm});
    upd_q.push_back({we, nw});

    n = 0;
    while (!snoop_ready_o && n < 20) begin step(); n++; end
    chk("ready_before", {31'd0, snoop_ready_o}, 32'd1);
    // cycle 0: present and accept
    snoop_valid_i = 1'b1; snoop_op_i = op; snoop_addr_i = addr;
    step();
    // cycle 1: LOOKUP
    snoop_valid_i = 1'b0; snoop_addr_i = 32'd0; snoop_op_i = 2'd0;
    chk("lookup_req", {31'd0, lookup_req_o}, 32'd1);
    chk("lookup_addr", lookup_addr_o, addr);
    chk("ready_busy", {31'd0, snoop_ready_o}, 32'd0);
    chk("hm_early", {31'd0, hm_valid_o}, 32'd0);
    lookup_ack_i = 1'b1; lookup_state_i = lst;
    step();
    // cycle 2: RESPOND
    lookup_ack_i = 1'b0; lookup_state_i = 4'd0;
    chk("hm_valid", {31'd0, hm_valid_o}, 32'd1);
    chk("lookup_idle_addr", lookup_addr_o, 32'd0);
    if (hm_valid_o && exp_q.size() > 0) begin
      e_hm = exp_q.pop_front();
      chk("hm_perr", {29'd0, proto_err_o, hm_out_o}, {29'd0, e_hm});
    end
    if (hm == 2'd2 && exp_hitm != 16'hFFFF) exp_hitm = exp_hitm + 16'd1;
    step();
    // cycle 3: WRITEBACK or UPDATE
    chk("hm_pulse", {31'd0, hm_valid_o}, 32'd0);
    chk("perr_pulse", {31'd0, proto_err_o}, 32'd0);
    chk("hitm_count", {16'd0, hitm_count_o}, {16'd0, exp_hitm});
    if (hm == 2'd2) begin
      chk("wb_req", {31'd0, wb_req_o}, 32'd1);
      chk("wb_addr", wb_addr_o, addr);
      chk("we_in_wb", {31'd0, state_we_o}, 32'd0);
      for (int i = 0; i < wb_wait; i++) begin
        step();
        chk("wb_hold", {31'd0, wb_req_o}, 32'd1);
      end
      wb_done_i = 1'b1;
      step();
      wb_done_i = 1'b0;
    end else begin
      chk("no_wb", {31'd0, wb_req_o}, 32'd0);
    end
    // UPDATE
    chk("upd_ready", {31'd0, snoop_ready_o}, 32'd0);
    chk("upd_wb", {31'd0, wb_req_o}, 32'd0);
    chk("wb_idle_addr", wb_addr_o, 32'd0);
    if (upd_q.size() > 0) begin
      e_upd = upd_q.pop_front();
      chk("state_we_new", {27'd0, state_we_o, state_new_o}, {27'd0, e_upd});
    end
    step();
    chk("ready_after", {31'd0, snoop_ready_o}, 32'd1);
    chk("we_after", {31'd0, state_we_o}, 32'd0);
  endtask

  initial begin
    int accepts, acc2_cyc, hm_cnt;
    // reset
    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    chk("rst_ready", {31'd0, snoop_ready_o}, 32'd1);
    chk("rst_outs", {26'd0, lookup_req_o, hm_valid_o, wb_req_o, state_we_o, proto_err_o, hm_out_o == 2'd0},
        32'd1);
    chk("rst_addrs", lookup_addr_o | wb_addr_o, 32'd0);
    chk("rst_hitm", {16'd0, hitm_count_o}, 32'd0);

    // directed snoops
    run_snoop(2'd0, 32'h0000_1000, 4'b0010, 0);   // READ of E
    run_snoop(2'd2, 32'hDEAD_BEE0, 4'b0001, 3);   // RFO of M with WB wait
    run_snoop(2'd3, 32'h0000_2000, 4'b1000, 0);   // INVALIDATE of I
    run_snoop(2'd0, 32'h0000_3000, 4'b0110, 0);   // corrupt state
    run_snoop(2'd1, $urandom(), 4'b0100, 0);      // WRITE of S
    run_snoop(2'd0, $urandom(), 4'b0001, 0);      // READ of M, no WB wait
    for (int k = 0; k < 6; k++) begin
      run_snoop(2'($urandom_range(0, 3)), $urandom(), 4'($urandom_range(0, 15)),
                $urandom_range(0, 3));
    end

    // second snoop held during busy period; ack held high throughout
    accepts = 0; acc2_cyc = -1; hm_cnt = 0;
    snoop_valid_i = 1'b1; snoop_op_i = 2'd0; snoop_addr_i = 32'hAAAA_0000;
    lookup_ack_i = 1'b1; lookup_state_i = 4'b0010;
    for (int i = 0; i < 12; i++) begin
      if (hm_valid_o) hm_cnt++;
      if (i == 5) chk("held_b_addr", lookup_addr_o, 32'hBBBB_0000);
      if (snoop_ready_o && snoop_valid_i) begin
        accepts++;
        if (accepts == 2) acc2_cyc = i;
      end else begin
        if (accepts == 1) snoop_addr_i = 32'hBBBB_0000;
        if (accepts == 2) snoop_valid_i = 1'b0;
      end
      step();
    end
    lookup_ack_i = 1'b0; lookup_state_i = 4'd0; snoop_valid_i = 1'b0;
    chk("held_accepts", accepts, 32'd2);
    chk("held_accept_cycle", acc2_cyc, 32'd4);
    chk("held_hm_count", hm_cnt, 32'd2);

    // reset during WRITEBACK, with valid asserted in the reset cycle
    snoop_valid_i = 1'b1; snoop_op_i = 2'd2; snoop_addr_i = 32'h5555_0040;
    step();
    snoop_valid_i = 1'b0;
    lookup_ack_i = 1'b1; lookup_state_i = 4'b0001;
    step();
    lookup_ack_i = 1'b0; lookup_state_i = 4'd0;
    step();
    chk("rwb_wb_req", {31'd0, wb_req_o}, 32'd1);
    step();
    chk("rwb_wb_wait", {31'd0, wb_req_o}, 32'd1);
    rst_i = 1'b1; snoop_valid_i = 1'b1;
    step();
    rst_i = 1'b0; snoop_valid_i = 1'b0;
    chk("rwb_wb_off", {31'd0, wb_req_o}, 32'd0);
    chk("rwb_ready", {31'd0, snoop_ready_o}, 32'd1);
    chk("rwb_hitm_clr", {16'd0, hitm_count_o}, 32'd0);
    chk("rwb_no_accept", {31'd0, lookup_req_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rwb_quiet", {28'd0, state_we_o, hm_valid_o, wb_req_o, snoop_ready_o}, 32'd1);
    end

    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("upd_q_empty", upd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
